scan_arbiter: RTL and testbench
===============================

# scan_arbiter

Round-robin arbiter that shares the single serial scan/parse unit (UART RX character parser returning one byte or a 32-bit hex address) between N_REQ command requesters inside the serial debug unit. Each requester raises a request with a type (byte or address). The arbiter grants one at a time, drives the scan unit's request/type handshake and captures its 32-bit result. It then returns that result to the granted requester with a one-cycle acknowledge. An optional watchdog aborts a scan that never completes.

## Interface
- N_REQ, 4: number of requesters, 2..8.
- TIMEOUT_CYC, 32'd100_000_000: watchdog limit in clk cycles. Used only with the timeout feature.
- IDW, $clog2(N_REQ): width of the grant index.

- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-high.
- req  in  N_REQ  per-requester request, level. Held until its ack.
- typ  in  N_REQ  per-requester type: 0 = byte, 1 = 32-bit address.
- ack  out  N_REQ  one-cycle completion pulse to the granted requester.
- err  out  N_REQ  one-cycle timeout flag, coincident with ack.
- dout  out  32  result; valid while ack is high and held until the next capture.
- gnt_id  out  IDW  index of the current/last grant.
- busy  out  1  high in any state other than IDLE.
- scn_req  out  1  request to scan unit; a one-cycle pulse.
- scn_type  out  1  type to scan unit; held from the REQ state until return to IDLE.
- scn_ack  in  1  scan unit done; scn_din valid while high.
- scn_din  in  32  scan unit result.
- scn_abort  out  1  one-cycle pulse that forces the scan unit back to idle.

## Operation
- States: IDLE, REQ, WAIT, DONE.
- IDLE:
  - If any req bit is set and scn_ack = 0, select the winner g, register gnt_id = g and scn_type = typ[g], then go to REQ.
  - Otherwise stay in IDLE.
- Winner selection: first set bit searching upward from ptr, wrapping modulo N_REQ.
  - ptr resets to 0, so requester 0 wins the first contest.
  - At every DONE, ptr is set to (g+1) mod N_REQ.
- REQ:
  - scn_req = 1 for exactly one cycle.
  - Clear the watchdog counter.
  - Go to WAIT.
- WAIT:
  - If scn_ack = 1: dout <= scn_din, then go to DONE.
  - If the timeout is enabled and the counter reaches TIMEOUT_CYC-1: dout <= 0, set the err-pending flag, then go to DONE.
- DONE:
  - ack[g] = 1. err[g] = err-pending. scn_abort = err-pending.
  - Clear err-pending.
  - Go to IDLE.
- Requester dropping req during REQ/WAIT: the transaction still completes and ack[g] still pulses. The requester ignores it.
- req bits that are high in DONE or in the cycle after DONE are not re-granted while scn_ack is still high. The IDLE guard on scn_ack = 0 prevents double capture of one scan result.
- Simultaneous scn_ack and timeout in WAIT: scn_ack wins, and err stays 0.
- Only one grant is outstanding at any time. ack and err are one-hot or zero.

## Timing
- Reset values:
  - state = IDLE, ptr = 0, gnt_id = 0.
  - ack = 0, err = 0, dout = 0.
  - scn_req = 0, scn_type = 0, scn_abort = 0, busy = 0.
  - Watchdog counter = 0.
- All outputs are registered.
- req sampled in IDLE at cycle t:
  - scn_req is high at t+1.
  - WAIT begins at t+2.
- scn_ack sampled high at cycle u: ack[g] and dout are valid at u+1, and the block is back in IDLE at u+2.
- Minimum req-to-ack latency: 3 cycles (scn_ack at t+2).
- Back-to-back grant: the next grant is decided in the first IDLE cycle with scn_ack = 0.
- Reset mid-operation returns to IDLE immediately. Any in-flight transaction is lost, with no ack.

## Configuration
- Macro: SCAN_ARB_TIMEOUT_EN.
- Defined:
  - A 32-bit watchdog counter runs only in WAIT.
  - Expiry gives ack + err pulses with dout = 0, and scn_abort is pulsed.
- Undefined:
  - No counter is built. WAIT exits only on scn_ack.
  - err and scn_abort are tied to 0.
  - TIMEOUT_CYC is unused.

## Structure
- Shared package scan_pkg holds:
  - state encoding constants ST_IDLE, ST_REQ, ST_WAIT, ST_DONE (2-bit);
  - type constants SCAN_BYTE = 1'b0 and SCAN_ADDR = 1'b1.
- One sub-module, rr_pick: combinational round-robin pick.
  - Inputs: req vector, ptr.
  - Outputs: valid, index.
- FSM, ptr, capture and watchdog stay in scan_arbiter.

## Test plan
- Single byte: req = 4'b0010, typ[1] = 0; scan unit returns 32'h0000_0041 three cycles after scn_req -> scn_type = 0, ack = 4'b0010 for 1 cycle, dout = 32'h41, gnt_id = 1.
- Round-robin fairness: all four req held continuously, each scan returning its index in scn_din -> grant order 0, 1, 2, 3, 0. The dout sequence matches the index of each grant.
- Address: req[3] with typ[3] = 1, scn_din = 32'hDEAD_BEEF -> scn_type = 1, ack[3] pulse, dout = 32'hDEADBEEF held after ack falls.
- Timeout (macro on, TIMEOUT_CYC = 16): no scn_ack -> exactly 16 WAIT cycles, then ack[g] and err[g] together, scn_abort for 1 cycle, dout = 0.
- Guard and race:
  - scn_ack held high 3 cycles while req[0] is re-raised -> no new scn_req until scn_ack = 0.
  - scn_ack in the same cycle as expiry -> err = 0.
- Reset mid-WAIT: assert rst -> all outputs 0 in the same cycle, no ack; after release, req[2] is granted (ptr = 0 search, no lower bit set).

Source files
------------

// File: rtl/scan_pkg.sv
// Shared encodings for the serial debug unit's scan arbiter: FSM states and scan types.
package scan_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } scan_state_e;

  localparam logic SCAN_BYTE = 1'b0;
  localparam logic SCAN_ADDR = 1'b1;

endpackage

// File: rtl/scan_arbiter_rr_pick.sv
// Combinational round-robin pick: first set req bit at or above ptr, wrapping modulo N_REQ.
module rr_pick #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned IDW   = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDW-1:0]   ptr,
  output logic             valid,
  output logic [IDW-1:0]   idx
);

  logic [IDW:0] k;

  // Scan downward so the last hit (smallest offset from ptr) wins.
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    k     = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      k = {1'b0, ptr} + (IDW+1)'(i);
      if (k >= (IDW+1)'(N_REQ)) k = k - (IDW+1)'(N_REQ);
      if (req[k[IDW-1:0]]) begin
        valid = 1'b1;
        idx   = k[IDW-1:0];
      end
    end
  end

endmodule

// File: rtl/scan_arbiter.sv
// Round-robin arbiter sharing one serial scan/parse unit between N_REQ requesters.
// Optional watchdog abort of a stuck scan: define SCAN_ARB_TIMEOUT_EN.
module scan_arbiter
  import scan_pkg::*;
#(
  parameter int unsigned N_REQ       = 4,
  parameter int unsigned TIMEOUT_CYC = 32'd100_000_000,
  parameter int unsigned IDW         = $clog2(N_REQ)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  input  logic [N_REQ-1:0] typ,
  output logic [N_REQ-1:0] ack,
  output logic [N_REQ-1:0] err,
  output logic [31:0]      dout,
  output logic [IDW-1:0]   gnt_id,
  output logic             busy,
  output logic             scn_req,
  output logic             scn_type,
  input  logic             scn_ack,
  input  logic [31:0]      scn_din,
  output logic             scn_abort
);

  scan_state_e    state;
  logic [IDW-1:0] ptr;
  logic           pick_valid;
  logic [IDW-1:0] pick_idx;
  logic           wd_expired;

  rr_pick #(
    .N_REQ (N_REQ),
    .IDW   (IDW)
  ) u_rr_pick (
    .req   (req),
    .ptr   (ptr),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

`ifdef SCAN_ARB_TIMEOUT_EN
  logic [31:0] wd_cnt;

  assign wd_expired = (wd_cnt == 32'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wd_cnt <= '0;
    end else if (state == ST_REQ) begin
      wd_cnt <= '0;
    end else if (state == ST_WAIT) begin
      wd_cnt <= wd_cnt + 32'd1;
    end
  end
`else
  assign wd_expired = 1'b0;
`endif

  // Outputs are registered on the transition into the state that owns them,
  // so ack/err/scn_abort are high exactly during DONE and scn_req during REQ.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      ptr       <= '0;
      gnt_id    <= '0;
      ack       <= '0;
      err       <= '0;
      dout      <= '0;
      busy      <= 1'b0;
      scn_req   <= 1'b0;
      scn_type  <= SCAN_BYTE;
      scn_abort <= 1'b0;
    end else begin
      ack       <= '0;
      err       <= '0;
      scn_req   <= 1'b0;
      scn_abort <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          // Holding off while scn_ack is high avoids capturing one result twice.
          if (pick_valid && !scn_ack) begin
            gnt_id   <= pick_idx;
            scn_type <= typ[pick_idx];
            scn_req  <= 1'b1;
            busy     <= 1'b1;
            state    <= ST_REQ;
          end
        end
        ST_REQ: begin
          state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (scn_ack) begin
            dout        <= scn_din;
            ack[gnt_id] <= 1'b1;
            state       <= ST_DONE;
          end else if (wd_expired) begin
            dout        <= '0;
            ack[gnt_id] <= 1'b1;
            err[gnt_id] <= 1'b1;
            scn_abort   <= 1'b1;
            state       <= ST_DONE;
          end
        end
        ST_DONE: begin
          ptr   <= (gnt_id == IDW'(N_REQ - 1)) ? '0 : gnt_id + 1'b1;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_scan_arbiter.sv
// Directed self-checking bench for scan_arbiter (N_REQ = 4, TIMEOUT_CYC = 16).
module tb_scan_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  req, typ, ack, err;
  logic [31:0] dout, scn_din;
  logic [1:0]  gnt_id;
  logic        busy, scn_req, scn_type, scn_ack, scn_abort;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  scan_arbiter #(
    .N_REQ       (4),
    .TIMEOUT_CYC (16)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .typ       (typ),
    .ack       (ack),
    .err       (err),
    .dout      (dout),
    .gnt_id    (gnt_id),
    .busy      (busy),
    .scn_req   (scn_req),
    .scn_type  (scn_type),
    .scn_ack   (scn_ack),
    .scn_din   (scn_din),
    .scn_abort (scn_abort)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk = n_chk + 1;
    assert (obs === exp) n_pass = n_pass + 1;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Wait (bounded) for the scn_req pulse, then check the grant it carries.
  task automatic wait_grant(input string tag, input logic [1:0] g, input logic t);
    for (int i = 0; i < 8 && !scn_req; i++) tick();
    chk({tag, "_scn_req"}, 32'(scn_req), 32'd1);
    chk({tag, "_gnt_id"}, 32'(gnt_id), 32'(g));
    chk({tag, "_scn_type"}, 32'(scn_type), 32'(t));
    chk({tag, "_busy"}, 32'(busy), 32'd1);
  endtask

  // From the REQ cycle: spend n_wait cycles, then return din; ends in the DONE cycle.
  task automatic finish_scan(input logic [31:0] din, input int n_wait);
    repeat (n_wait) tick();
    scn_ack = 1'b1;
    scn_din = din;
    tick();
  endtask

  task automatic release_all();
    req     = '0;
    scn_ack = 1'b0;
    tick();
  endtask

  initial begin
    req = '0; typ = '0; scn_ack = 1'b0; scn_din = '0;
    tick();
    tick();
    chk("rst_ack", 32'(ack), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_dout", dout, 32'd0);
    chk("rst_gnt", 32'(gnt_id), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_scn_req", 32'(scn_req), 32'd0);
    chk("rst_scn_abort", 32'(scn_abort), 32'd0);
    rst = 1'b0;
    tick();

    // Single byte from requester 1; ptr becomes 2.
    req = 4'b0010; typ = 4'b0000;
    wait_grant("byte", 2'd1, 1'b0);
    tick();
    chk("byte_req_pulse", 32'(scn_req), 32'd0);
    finish_scan(32'h0000_0041, 2);
    chk("byte_ack", 32'(ack), 32'b0010);
    chk("byte_dout", dout, 32'h41);
    chk("byte_err", 32'(err), 32'd0);
    release_all();
    chk("byte_ack_fall", 32'(ack), 32'd0);
    chk("byte_idle", 32'(busy), 32'd0);

    // Address from requester 3; ptr wraps to 0.
    req = 4'b1000; typ = 4'b1000;
    wait_grant("addr", 2'd3, 1'b1);
    finish_scan(32'hDEAD_BEEF, 1);
    chk("addr_ack", 32'(ack), 32'b1000);
    release_all();
    chk("addr_ack_fall", 32'(ack), 32'd0);
    chk("addr_dout_held", dout, 32'hDEAD_BEEF);

    // All four held: grants 0,1,2,3,0; ptr ends at 1.
    req = 4'b1111; typ = 4'b0000;
    for (int n = 0; n < 5; n++) begin
      wait_grant("rr", 2'(n % 4), 1'b0);
      finish_scan(32'(n % 4), 1);
      chk("rr_ack", 32'(ack), 32'd1 << (n % 4));
      chk("rr_dout", dout, 32'(n % 4));
      scn_ack = 1'b0;
    end
    release_all();

    // scn_ack high for three sampled cycles while req[0] stays up.
    req = 4'b0001;
    wait_grant("guard", 2'd0, 1'b0);
    finish_scan(32'd5, 1);
    chk("guard_ack", 32'(ack), 32'b0001);
    tick();
    chk("guard_no_req1", 32'(scn_req), 32'd0);
    chk("guard_no_ack", 32'(ack), 32'd0);
    tick();
    chk("guard_no_req2", 32'(scn_req), 32'd0);
    chk("guard_idle", 32'(busy), 32'd0);
    scn_ack = 1'b0;
    tick();
    chk("guard_regrant", 32'(scn_req), 32'd1);
    chk("guard_regrant_gnt", 32'(gnt_id), 32'd0);
    finish_scan(32'd6, 1);
    chk("guard2_ack", 32'(ack), 32'b0001);
    chk("guard2_dout", dout, 32'd6);
    release_all();

`ifdef SCAN_ARB_TIMEOUT_EN
    // 16 WAIT cycles, then ack+err with dout cleared and an abort pulse.
    req = 4'b0010;
    wait_grant("to", 2'd1, 1'b0);
    repeat (16) tick();
    chk("to_early_ack", 32'(ack), 32'd0);
    tick();
    chk("to_ack", 32'(ack), 32'b0010);
    chk("to_err", 32'(err), 32'b0010);
    chk("to_abort", 32'(scn_abort), 32'd1);
    chk("to_dout", dout, 32'd0);
    req = '0;
    tick();
    chk("to_abort_fall", 32'(scn_abort), 32'd0);
    chk("to_err_fall", 32'(err), 32'd0);

    // scn_ack on the expiry cycle wins.
    req = 4'b0010;
    wait_grant("race", 2'd1, 1'b0);
    repeat (16) tick();
    scn_ack = 1'b1;
    scn_din = 32'd77;
    tick();
    chk("race_ack", 32'(ack), 32'b0010);
    chk("race_err", 32'(err), 32'd0);
    chk("race_abort", 32'(scn_abort), 32'd0);
    chk("race_dout", dout, 32'd77);
    release_all();
`else
    // Without the watchdog a long scan simply waits.
    req = 4'b0010;
    wait_grant("long", 2'd1, 1'b0);
    repeat (40) tick();
    chk("long_no_ack", 32'(ack), 32'd0);
    chk("long_busy", 32'(busy), 32'd1);
    finish_scan(32'd77, 0);
    chk("long_ack", 32'(ack), 32'b0010);
    chk("long_err", 32'(err), 32'd0);
    chk("long_abort", 32'(scn_abort), 32'd0);
    chk("long_dout", dout, 32'd77);
    release_all();
`endif

    // Complete a grant to 2 so ptr = 3, then reset in the middle of the next one.
    req = 4'b0100; typ = 4'b0100;
    wait_grant("pre", 2'd2, 1'b1);
    finish_scan(32'd9, 1);
    release_all();
    req = 4'b0100;
    wait_grant("mid", 2'd2, 1'b1);
    tick();
    tick();
    rst = 1'b1;
    #1;
    chk("mrst_busy", 32'(busy), 32'd0);
    chk("mrst_gnt", 32'(gnt_id), 32'd0);
    chk("mrst_dout", dout, 32'd0);
    chk("mrst_type", 32'(scn_type), 32'd0);
    chk("mrst_ack", 32'(ack), 32'd0);
    req = 4'b1100; typ = 4'b0000;
    tick();
    rst = 1'b0;
    chk("mrst_no_ack", 32'(ack), 32'd0);
    wait_grant("post", 2'd2, 1'b0);
    finish_scan(32'd3, 1);
    chk("post_ack", 32'(ack), 32'b0100);
    release_all();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
